// File: rtl/score_bcd_encoder.sv
// Sequential double-dabble binary-to-BCD encoder for the game score.
// Publishes four packed BCD digits, a leading-zero blank mask and a saturation flag.
module score_bcd_encoder #(
  parameter int IN_W    = 16,
  parameter int MAX_VAL = 9999
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [IN_W-1:0] bin_in,
  output logic            busy,
  output logic            done,
  output logic [15:0]     bcd_out,
  output logic [3:0]      blank_mask,
  output logic            overflow
);

  localparam int ITER_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [IN_W-1:0]   MAX_SAT   = IN_W'(MAX_VAL);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(IN_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FINISH
  } state_t;

  state_t            state;
  logic [IN_W-1:0]   sat;
  logic [15:0]       scratch;
  logic [15:0]       adj;
  logic [ITER_W-1:0] iter;
  logic              ovf_pend;

  // Add-3 correction on every nibble that would overflow a decimal digit when doubled.
  always_comb begin
    adj = scratch;
    for (int unsigned i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sat        <= '0;
      scratch    <= '0;
      iter       <= '0;
      ovf_pend   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd_out    <= '0;
      blank_mask <= 4'b1110;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sat      <= (bin_in > MAX_SAT) ? MAX_SAT : bin_in;
            ovf_pend <= (bin_in > MAX_SAT);
            scratch  <= '0;
            iter     <= '0;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          scratch <= {adj[14:0], sat[IN_W-1]};
          sat     <= sat << 1;
          iter    <= iter + 1'b1;
          if (iter == LAST_ITER)
            state <= FINISH;
        end
        FINISH: begin
          bcd_out       <= scratch;
          overflow      <= ovf_pend;
          blank_mask[3] <= (scratch[15:12] == 4'd0);
          blank_mask[2] <= (scratch[15:12] == 4'd0) && (scratch[11:8] == 4'd0);
          blank_mask[1] <= (scratch[15:12] == 4'd0) && (scratch[11:8] == 4'd0)
                           && (scratch[7:4] == 4'd0);
          blank_mask[0] <= 1'b0;
          done          <= 1'b1;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_encoder.sv
// Directed bench for score_bcd_encoder: latency, digit/mask values, saturation, ignored start, reset abort.
module tb_score_bcd_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic [3:0]  blank_mask;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [15:0] prev_bcd;
  logic [3:0]  prev_mask;
  logic        prev_ovf;

  score_bcd_encoder #(.IN_W(16), .MAX_VAL(9999)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .bcd_out    (bcd_out),
    .blank_mask (blank_mask),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Issue one start with val, optionally pulse start again at negedge index inj, then check timing and results.
  task automatic run(input string name, input logic [15:0] val, input int inj,
                     input logic [15:0] eb, input logic [3:0] em, input logic eo);
    int busy_cnt;
    int done_cnt;
    int done_at;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    @(negedge clk);
    bin_in = val;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 16'd1234;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = i;
      end
      if (i == 8) begin
        chk({name, " hold bcd"}, 32'(bcd_out), 32'(prev_bcd));
        chk({name, " hold mask"}, 32'(blank_mask), 32'(prev_mask));
        chk({name, " hold ovf"}, 32'(overflow), 32'(prev_ovf));
      end
      if (i == inj) begin
        start  = 1'b1;
        bin_in = 16'd500;
      end else begin
        start = 1'b0;
      end
    end
    chk({name, " busy cycles"}, 32'(busy_cnt), 32'd17);
    chk({name, " done count"}, 32'(done_cnt), 32'd1);
    chk({name, " done cycle"}, 32'(done_at), 32'd17);
    chk({name, " bcd"}, 32'(bcd_out), 32'(eb));
    chk({name, " mask"}, 32'(blank_mask), 32'(em));
    chk({name, " ovf"}, 32'(overflow), 32'(eo));
    prev_bcd  = eb;
    prev_mask = em;
    prev_ovf  = eo;
  endtask

  initial begin
    int done_cnt;
    rst    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    prev_bcd  = 16'h0000;
    prev_mask = 4'b1110;
    prev_ovf  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset bcd", 32'(bcd_out), 32'h0000);
    chk("reset mask", 32'(blank_mask), 32'b1110);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset ovf", 32'(overflow), 32'd0);

    run("v24",    16'd24,    -1, 16'h0024, 4'b1100, 1'b0);
    run("v0",     16'd0,     -1, 16'h0000, 4'b1110, 1'b0);
    run("v7",     16'd7,     -1, 16'h0007, 4'b1110, 1'b0);
    run("v100",   16'd100,   -1, 16'h0100, 4'b1000, 1'b0);
    run("v1000",  16'd1000,  -1, 16'h1000, 4'b0000, 1'b0);
    run("v9999",  16'd9999,  -1, 16'h9999, 4'b0000, 1'b0);
    run("v12345", 16'd12345, -1, 16'h9999, 4'b0000, 1'b1);
    run("v65535", 16'd65535, -1, 16'h9999, 4'b0000, 1'b1);
    run("v5",     16'd5,     -1, 16'h0005, 4'b1110, 1'b0);
    run("v24b",   16'd24,    -1, 16'h0024, 4'b1100, 1'b0);
    run("ignore", 16'd24,     5, 16'h0024, 4'b1100, 1'b0);

    // Reset abort in the middle of a 9999 conversion.
    @(negedge clk);
    bin_in = 16'd9999;
    start  = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (done) done_cnt++;
      if (i == 8) begin
        chk("abort busy before rst", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort bcd", 32'(bcd_out), 32'h0000);
        chk("abort mask", 32'(blank_mask), 32'b1110);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort ovf", 32'(overflow), 32'd0);
      end
      if (i == 10) rst = 1'b0;
    end
    chk("abort no done", 32'(done_cnt), 32'd0);
    prev_bcd  = 16'h0000;
    prev_mask = 4'b1110;
    prev_ovf  = 1'b0;

    run("v42", 16'd42, -1, 16'h0042, 4'b1100, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/score_bcd_encoder.md
Name: score_bcd_encoder

Overview:
- Sequential binary-to-BCD encoder for the 16-bit game score. It is the encoding counterpart to the seven-segment score path.
- Accepts a binary score on a start strobe and runs a 16-step shift-and-add-3 (double-dabble) conversion.
- Publishes four packed BCD digits plus a leading-zero blank mask, from which the HEX0..HEX3 segment decode is driven.
- Sits between the game FSM and the display decoders, and replaces the combinational divide/modulo digit split.

Parameters:
- IN_W, 16: binary input width; also the number of conversion iterations.
- MAX_VAL, 9999: saturation ceiling applied to the input; the largest value representable in 4 BCD digits.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion of bin_in; sampled only in IDLE.
- bin_in  input  16  binary score from the game FSM.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out, blank_mask and overflow update.
- bcd_out  output  16  packed digits: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- blank_mask  output  4  bit i = 1 means digit i is a leading zero and must be blanked; bit 0 is always 0.
- overflow  output  1  last converted input exceeded MAX_VAL and was saturated.

Behaviour:
- Reset (asynchronous, active-high, any state): state=IDLE, busy=0, done=0, bcd_out=16'h0000, blank_mask=4'b1110, overflow=0, shift/iteration registers cleared.
- States:
  - IDLE: waits for start.
  - CONV: runs 16 iterations.
  - FINISH: one cycle; publishes results.
  - After FINISH the block returns to IDLE.
- IDLE -> CONV on the rising edge where start=1:
  - Capture sat = (bin_in > MAX_VAL) ? MAX_VAL : bin_in.
  - Capture ovf_pend = (bin_in > MAX_VAL).
  - Clear the 16-bit BCD scratch register; iter=0; busy=1.
- CONV, each cycle:
  - For every scratch nibble >= 5, add 3 to that nibble.
  - Then shift {scratch, sat} left by 1.
  - iter increments. After the shift with iter==15, go to FINISH.
  - CONV lasts exactly 16 cycles.
- FINISH:
  - bcd_out <= scratch; overflow <= ovf_pend.
  - blank_mask[3] = (d3==0).
  - blank_mask[2] = (d3==0 && d2==0).
  - blank_mask[1] = (d3==0 && d2==0 && d1==0).
  - blank_mask[0] = 0.
  - done=1 for this single cycle; busy=0 on the following edge; state -> IDLE.
- Latency: start sampled at edge N; busy is high for cycles N+1..N+17. Registered outputs change at edge N+17, and done is high during the cycle following edge N+17 only.
- Outputs bcd_out, blank_mask and overflow hold their previous values throughout CONV. They never show partial results.
- start while busy (CONV or FINISH) is ignored, with no queuing. start held high continuously re-triggers on the first IDLE cycle after FINISH.
- bin_in is used only at the start edge; changes during CONV have no effect.
- Saturation: inputs 10000..65535 convert as 9999 with overflow=1. An input of exactly 9999 gives overflow=0.
- Reset mid-conversion: the conversion is abandoned, outputs return to reset values immediately, and there is no done pulse.
- Width rules: scratch digits never exceed 9 after any shift, because the input is at most 9999. No 5th digit exists.

Test Plan:
- Reset release, no start -> bcd_out=0000, blank_mask=1110, busy=0, done=0, overflow=0.
- start with bin_in=24 -> busy high 17 cycles; done one cycle; bcd_out=16'h0024, blank_mask=1100, overflow=0.
- Sweep bin_in = 0, 7, 100, 1000, 9999:
  - 0 -> bcd 0000, mask 1110.
  - 7 -> bcd 0007, mask 1110.
  - 100 -> bcd 0100, mask 1000.
  - 1000 -> bcd 1000, mask 0000.
  - 9999 -> bcd 9999, mask 0000, overflow=0.
- bin_in=12345, then 65535 -> bcd_out=16'h9999, mask 0000, overflow=1. A following start with 5 -> bcd 0005, overflow=0.
- Convert 24, then pulse start with bin_in=500 at cycle 5 of CONV -> ignored; result stays 0024; exactly one done.
- Assert rst at cycle 8 of a 9999 conversion that follows a completed 24 conversion -> outputs immediately reset values; no done pulse. A new start with 42 -> bcd 0042 after 17 cycles.
